// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: IFU fetches and LSU loads/stores share one memory port.
// LSU has priority; a saturating starvation counter forces an IFU win after StarveLimit LSU grants.
module mem_arbiter #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,
  input  logic                 ifu_req,
  input  logic [AddrWidth-1:0] ifu_addr,
  output logic                 ifu_gnt,
  output logic                 ifu_rvalid,
  output logic [DataWidth-1:0] ifu_rdata,
  input  logic                 lsu_req,
  input  logic                 lsu_we,
  input  logic [3:0]           lsu_be,
  input  logic [AddrWidth-1:0] lsu_addr,
  input  logic [DataWidth-1:0] lsu_wdata,
  output logic                 lsu_gnt,
  output logic                 lsu_rvalid,
  output logic [DataWidth-1:0] lsu_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [3:0]           mem_be,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [DataWidth-1:0] mem_rdata
);

  localparam int unsigned CntWidth = 4;
  localparam logic [CntWidth-1:0] Limit = CntWidth'(StarveLimit);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IFU_BUSY = 2'd1,
    LSU_BUSY = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] starve_q, starve_d;
  logic                ifu_win, lsu_win;

  // State and starvation counter registers
  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Winner selection: IFU only beats a concurrent LSU request once starved
  always_comb begin
    ifu_win = 1'b0;
    lsu_win = 1'b0;
    if (state_q == IDLE) begin
      ifu_win = ifu_req && (!lsu_req || (starve_q == Limit));
      lsu_win = lsu_req && !ifu_win;
    end
  end

  // Next state, counter and all port outputs
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    ifu_gnt    = 1'b0;
    ifu_rvalid = 1'b0;
    ifu_rdata  = '0;
    lsu_gnt    = 1'b0;
    lsu_rvalid = 1'b0;
    lsu_rdata  = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 4'h0;
    mem_addr   = '0;
    mem_wdata  = '0;

    if (brq_rst) begin
      state_d  = IDLE;
      starve_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ifu_win) begin
            mem_req  = 1'b1;
            mem_be   = 4'hF;
            mem_addr = ifu_addr;
            ifu_gnt  = mem_gnt;
            if (mem_gnt) state_d = IFU_BUSY;
          end else if (lsu_win) begin
            mem_req   = 1'b1;
            mem_we    = lsu_we;
            mem_be    = lsu_be;
            mem_addr  = lsu_addr;
            mem_wdata = lsu_wdata;
            lsu_gnt   = mem_gnt;
            if (mem_gnt) state_d = LSU_BUSY;
          end

          if (ifu_gnt || !ifu_req) begin
            starve_d = '0;
          end else if (lsu_gnt && (starve_q < Limit)) begin
            starve_d = starve_q + CntWidth'(1);
          end
        end
        IFU_BUSY: begin
          if (mem_rvalid) begin
            ifu_rvalid = 1'b1;
            ifu_rdata  = mem_rdata;
            state_d    = IDLE;
          end
        end
        LSU_BUSY: begin
          if (mem_rvalid) begin
            lsu_rvalid = 1'b1;
            lsu_rdata  = mem_rdata;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned LIM = 4;

  logic          brq_clk = 1'b0;
  logic          brq_rst = 1'b1;
  logic          ifu_req = 1'b0;
  logic [AW-1:0] ifu_addr = '0;
  logic          ifu_gnt, ifu_rvalid;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req = 1'b0;
  logic          lsu_we = 1'b0;
  logic [3:0]    lsu_be = 4'h0;
  logic [AW-1:0] lsu_addr = '0;
  logic [DW-1:0] lsu_wdata = '0;
  logic          lsu_gnt, lsu_rvalid;
  logic [DW-1:0] lsu_rdata;
  logic          mem_req, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.DataWidth(DW), .AddrWidth(AW), .StarveLimit(LIM)) dut (
    .brq_clk(brq_clk), .brq_rst(brq_rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_be(lsu_be), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
    .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 brq_clk = ~brq_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model: who owns the single outstanding transaction (0 none, 1 IFU, 2 LSU)
  // and how many LSU grants the waiting IFU has watched, capped at LIM.
  int m_owner = 0, m_lsu_wins = 0;
  int n_owner = 0, n_lsu_wins = 0;
  bit ifu_taken = 1'b0, lsu_taken = 1'b0;

  always @(negedge brq_clk) begin
    int win;
    logic [31:0] e_ctrl, e_addr, e_wdata, e_ird, e_lrd;
    logic e_ig, e_lg;
    e_ctrl = '0; e_addr = '0; e_wdata = '0; e_ird = '0; e_lrd = '0;
    e_ig = 1'b0; e_lg = 1'b0;
    n_owner = m_owner;
    n_lsu_wins = m_lsu_wins;
    if (brq_rst) begin
      n_owner = 0;
      n_lsu_wins = 0;
    end else if (m_owner == 0) begin
      if (ifu_req && lsu_req) win = (m_lsu_wins == LIM) ? 1 : 2;
      else if (ifu_req) win = 1;
      else if (lsu_req) win = 2;
      else win = 0;
      if (win == 1) begin
        e_ig = mem_gnt;
        e_ctrl = {22'd0, e_ig, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF};
        e_addr = ifu_addr;
      end else if (win == 2) begin
        e_lg = mem_gnt;
        e_ctrl = {22'd0, 1'b0, 1'b0, e_lg, 1'b0, 1'b1, lsu_we, lsu_be};
        e_addr = lsu_addr;
        e_wdata = lsu_wdata;
      end
      if (mem_gnt && win != 0) n_owner = win;
      if (!ifu_req || e_ig) n_lsu_wins = 0;
      else if (e_lg) n_lsu_wins = (m_lsu_wins + 1 > LIM) ? LIM : m_lsu_wins + 1;
    end else if (mem_rvalid) begin
      if (m_owner == 1) begin
        e_ctrl = {22'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
        e_ird = mem_rdata;
      end else begin
        e_ctrl = {22'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
        e_lrd = mem_rdata;
      end
      n_owner = 0;
    end
    chk("model_ctrl", {22'd0, ifu_gnt, ifu_rvalid, lsu_gnt, lsu_rvalid, mem_req, mem_we, mem_be}, e_ctrl);
    chk("model_mem_addr", mem_addr, e_addr);
    chk("model_mem_wdata", mem_wdata, e_wdata);
    chk("model_ifu_rdata", ifu_rdata, e_ird);
    chk("model_lsu_rdata", lsu_rdata, e_lrd);
    ifu_taken = ifu_gnt;
    lsu_taken = lsu_gnt;
  end

  always @(posedge brq_clk) begin
    m_owner = n_owner;
    m_lsu_wins = n_lsu_wins;
  end

  task automatic step();
    @(posedge brq_clk);
    #1;
  endtask

  initial begin
    int grants[$];
    int exp_seq[6];
    exp_seq = '{2, 2, 2, 2, 1, 2};

    // Reset state
    step();
    @(negedge brq_clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_gnts", {30'd0, ifu_gnt, lsu_gnt}, 32'd0);
    step();
    brq_rst = 1'b0;

    // Single IFU fetch
    ifu_req = 1'b1; ifu_addr = 32'h100; mem_gnt = 1'b1;
    @(negedge brq_clk);
    chk("fetch_ifu_gnt", {31'd0, ifu_gnt}, 32'd1);
    chk("fetch_mem_addr", mem_addr, 32'h100);
    step();
    ifu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge brq_clk);
    chk("fetch_ifu_rvalid", {31'd0, ifu_rvalid}, 32'd1);
    chk("fetch_ifu_rdata", ifu_rdata, 32'hDEADBEEF);
    chk("fetch_lsu_rvalid", {31'd0, lsu_rvalid}, 32'd0);
    step();

    // Simultaneous requests, LSU store wins
    mem_rvalid = 1'b0;
    ifu_req = 1'b1; ifu_addr = 32'h104;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h2000; lsu_wdata = 32'h55AA; lsu_be = 4'b0011;
    mem_gnt = 1'b1;
    @(negedge brq_clk);
    chk("both_lsu_gnt", {31'd0, lsu_gnt}, 32'd1);
    chk("both_ifu_gnt", {31'd0, ifu_gnt}, 32'd0);
    chk("both_mem_we_be", {27'd0, mem_we, mem_be}, 32'h13);
    chk("both_mem_wdata", mem_wdata, 32'h55AA);
    step();
    lsu_req = 1'b0; lsu_we = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
    @(negedge brq_clk);
    chk("store_done", {30'd0, lsu_rvalid, ifu_rvalid}, 32'd2);
    step();
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    @(negedge brq_clk);
    chk("waiting_ifu_gnt", {31'd0, ifu_gnt}, 32'd1);
    step();
    mem_gnt = 1'b0; ifu_req = 1'b0; mem_rvalid = 1'b1;
    step();

    // Starvation: 4 LSU grants, then IFU, then LSU again
    ifu_req = 1'b1; lsu_req = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1;
    for (int c = 0; c < 30 && grants.size() < 6; c++) begin
      @(negedge brq_clk);
      if (ifu_gnt) grants.push_back(1);
      else if (lsu_gnt) grants.push_back(2);
    end
    chk("starve_grant_count", grants.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < grants.size()) chk($sformatf("starve_grant_%0d", i), grants[i], exp_seq[i]);
    end
    step();
    ifu_req = 1'b0; lsu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;

    // Memory backpressure
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_be = 4'hF; lsu_addr = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      @(negedge brq_clk);
      chk("bp_mem_req", {31'd0, mem_req}, 32'd1);
      chk("bp_lsu_gnt", {31'd0, lsu_gnt}, 32'd0);
      step();
    end
    mem_gnt = 1'b1;
    @(negedge brq_clk);
    chk("bp_lsu_gnt_rise", {31'd0, lsu_gnt}, 32'd1);
    chk("bp_mem_addr", mem_addr, 32'h3000);
    step();

    // Reset while LSU_BUSY, then a late response
    lsu_req = 1'b0; mem_gnt = 1'b0; brq_rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234;
    @(negedge brq_clk);
    chk("rst_busy_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy_lsu_rvalid", {31'd0, lsu_rvalid}, 32'd0);
    step();
    brq_rst = 1'b0;
    @(negedge brq_clk);
    chk("late_rvalid", {30'd0, ifu_rvalid, lsu_rvalid}, 32'd0);
    step();
    @(negedge brq_clk);
    chk("spurious_rvalid", {30'd0, ifu_rvalid, lsu_rvalid}, 32'd0);
    step();
    mem_rvalid = 1'b0; ifu_req = 1'b1; ifu_addr = 32'h40; mem_gnt = 1'b1;
    @(negedge brq_clk);
    chk("still_idle_ifu_gnt", {31'd0, ifu_gnt}, 32'd1);
    step();
    ifu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001;
    @(negedge brq_clk);
    chk("post_rst_fetch", ifu_rdata, 32'hCAFE0001);
    step();
    mem_rvalid = 1'b0;

    // Random traffic; requesters hold their request until granted
    for (int c = 0; c < 4000; c++) begin
      if (!ifu_req || ifu_taken) begin
        ifu_req = ($urandom_range(0, 1) == 1);
        ifu_addr = $urandom;
      end
      if (!lsu_req || lsu_taken) begin
        lsu_req = ($urandom_range(0, 1) == 1);
        lsu_we = ($urandom_range(0, 1) == 1);
        lsu_be = 4'($urandom_range(0, 15));
        lsu_addr = $urandom;
        lsu_wdata = $urandom;
      end
      mem_gnt = ($urandom_range(0, 3) != 0);
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      brq_rst = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DataWidth, default 32, width of data buses.
REQ-002 Parameter AddrWidth, default 32, width of address buses.
REQ-003 Parameter StarveLimit, default 4, consecutive LSU wins allowed while the IFU waits; range 1-15.
REQ-004 Single clock, brq_clk; reset brq_rst is synchronous and active-high; all state updates on the rising edge of brq_clk.
REQ-005 Ports (name, direction, width, meaning):
- brq_clk, in, 1: clock.
- brq_rst, in, 1: synchronous active-high reset.
- ifu_req, in, 1: fetch request.
- ifu_addr, in, AddrWidth: fetch address.
- ifu_gnt, out, 1: fetch request accepted.
- ifu_rvalid, out, 1: fetch data valid.
- ifu_rdata, out, DataWidth: fetch data.
- lsu_req, in, 1: load/store request.
- lsu_we, in, 1: 1 = store.
- lsu_be, in, 4: byte enables.
- lsu_addr, in, AddrWidth: load/store address.
- lsu_wdata, in, DataWidth: store data.
- lsu_gnt, out, 1: load/store request accepted.
- lsu_rvalid, out, 1: load data valid, or store complete.
- lsu_rdata, out, DataWidth: load data.
- mem_req, out, 1: memory request.
- mem_we, out, 1: memory write.
- mem_be, out, 4: memory byte enables.
- mem_addr, out, AddrWidth: memory address.
- mem_wdata, out, DataWidth: memory write data.
- mem_gnt, in, 1: memory accepted the request.
- mem_rvalid, in, 1: memory response valid; asserted for reads and writes.
- mem_rdata, in, DataWidth: memory read data.

Function
REQ-006 FSM states: IDLE, IFU_BUSY, LSU_BUSY. At most one memory transaction is outstanding.
REQ-007 In IDLE, winner selection is combinational and uses no register delay:
- If only one requester is asserting req, that requester wins.
- If both are asserting req, the LSU wins unless starve_cnt == StarveLimit, in which case the IFU wins.
REQ-008 In IDLE with a winner:
- mem_req = 1.
- mem_addr, mem_we, mem_be and mem_wdata come from the winner.
- For an IFU winner, mem_we = 0, mem_be = 4'hF and mem_wdata = 0.
REQ-009 In IDLE with no requester asserting req, mem_req = 0 and all other mem_* outputs are 0.
REQ-010 ifu_gnt = mem_gnt AND IDLE AND IFU is the winner; lsu_gnt is defined the same way for the LSU. Both are never 1 in the same cycle.
REQ-011 If mem_gnt = 0 in IDLE, the FSM stays in IDLE and re-arbitrates next cycle. Requesters hold req and payload until they see gnt.
REQ-012 On a grant in IDLE, the next state is IFU_BUSY or LSU_BUSY according to the winner.
REQ-013 In either BUSY state, mem_req = 0 and ifu_gnt = lsu_gnt = 0.
REQ-014 In a BUSY state with mem_rvalid = 1:
- The owner's rvalid = 1 for that cycle, combinationally.
- The owner's rdata = mem_rdata.
- The next state is IDLE.
REQ-015 The non-owner's rvalid is 0.
REQ-016 ifu_rdata and lsu_rdata equal mem_rdata whenever the corresponding rvalid = 1, and are 0 otherwise.
REQ-017 Back-to-back throughput is one grant per two cycles minimum: the grant cycle, then the response cycle.
REQ-018 A new request is accepted only in the cycle after the response, never in the same cycle as it.
REQ-019 mem_rvalid asserted while in IDLE is ignored: no rvalid output and no state change.
REQ-020 starve_cnt is a 4-bit counter with these rules:
- It increments on each lsu_gnt while ifu_req = 1.
- It saturates at StarveLimit.
- It clears to 0 on ifu_gnt.
- It clears to 0 in any cycle where ifu_req = 0 and the FSM is in IDLE.
REQ-021 mem_gnt asserted while in a BUSY state is ignored.

Reset
REQ-022 While brq_rst = 1:
- The state becomes IDLE and starve_cnt = 0 at the next edge.
- All outputs are forced to 0 in the same cycle, including mem_req, both gnts, both rvalids, both rdatas and all mem_* payload.
REQ-023 Reset asserted mid-transaction (in a BUSY state) abandons the transaction. A late mem_rvalid after reset is ignored by REQ-019.

Verification
REQ-024 Single IFU fetch: ifu_req = 1, ifu_addr = 0x100, mem_gnt = 1 in the same cycle.
- Required response: ifu_gnt = 1 and mem_addr = 0x100.
- Next cycle, mem_rvalid = 1 and mem_rdata = 0xDEADBEEF give ifu_rvalid = 1 and ifu_rdata = 0xDEADBEEF, with lsu_rvalid = 0.
REQ-025 Simultaneous requests with starve_cnt = 0: ifu_req = lsu_req = 1, lsu_we = 1, lsu_addr = 0x2000, lsu_wdata = 0x55AA, lsu_be = 4'b0011.
- Required response: lsu_gnt = 1, mem_we = 1, mem_be = 4'b0011, mem_wdata = 0x55AA, ifu_gnt = 0.
- Then starve_cnt = 1.
REQ-026 Starvation: ifu_req and lsu_req held high, mem_gnt and mem_rvalid always 1.
- Required grant sequence: LSU granted 4 times, then IFU granted.
- starve_cnt returns to 0 after the IFU grant.
REQ-027 Memory backpressure: lsu_req = 1 with mem_gnt = 0 for 3 cycles.
- Required response: mem_req = 1 held, lsu_gnt = 0 and state IDLE throughout.
- Grant occurs in the cycle mem_gnt rises.
REQ-028 Reset in LSU_BUSY: brq_rst = 1 for 1 cycle, then mem_rvalid = 1.
- Required response: no lsu_rvalid pulse, state IDLE, mem_req = 0 during reset.
REQ-029 Spurious response: mem_rvalid = 1 while idle with no requests.
- Required response: ifu_rvalid = lsu_rvalid = 0 and state unchanged.
